// File: rtl/dmem_responder_pkg.sv
// Shared processor package: data-memory geometry and responder state encoding.
// Every dmem_responder file imports it, so the defaults and the encoding live in one place.
package dmem_responder_pkg;

  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_DW    = 32;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 word store with synchronous write and registered read.
// The storage is not reset. The read register holds its value until the next read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DMEM_DW-1:0] wdata_i,
  output logic [DMEM_DW-1:0] rdata_o
);

  logic [DMEM_DW-1:0] mem_q [DEPTH];
  logic [DMEM_DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clears the store after reset, then serves one load/store
// at a time through an IDLE -> ACCESS -> RESPOND handshake, flagging out-of-range addresses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int SP_INIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [DMEM_DW-1:0] req_addr,
  input  logic [DMEM_DW-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DMEM_DW-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic [7:0]         err_count,
  output logic               clear_done
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam logic [DMEM_DW-1:0] DEPTH_W  = DMEM_DW'(DEPTH);
  localparam logic [AW-1:0]      LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]      SP_IDX   = AW'(SP_INIT);
  localparam logic [DMEM_DW-1:0] SP_MARK  = DMEM_DW'(DEPTH - 1);

  dmem_state_e        state_q, state_d;
  logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
  logic               clear_done_q;
  logic               we_q;
  logic [DMEM_DW-1:0] addr_q;
  logic [DMEM_DW-1:0] wdata_q;
  logic [7:0]         err_count_q;

  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DMEM_DW-1:0] mem_wdata;
  logic [DMEM_DW-1:0] mem_rdata;

  logic addr_err;
  logic req_fire;
  logic rsp_fire;

  // Full-width compare so huge addresses never alias onto a valid word.
  assign addr_err = (addr_q >= DEPTH_W);
  assign req_fire = (state_q == IDLE) && req_valid;
  assign rsp_fire = (state_q == RESPOND) && rsp_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q[AW-1:0];
    mem_wdata = wdata_q;
    unique case (state_q)
      CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = (clr_cnt_q == SP_IDX) ? SP_MARK : '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en  = !addr_err;
        mem_we  = we_q;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_count_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if ((state_q == CLEAR) && (clr_cnt_q == LAST_IDX)) begin
        clear_done_q <= 1'b1;
      end
      if (req_fire) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (rsp_fire && addr_err && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Outputs derive from the state so reset clears them immediately.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESPOND);
  assign rsp_err    = rsp_valid && addr_err;
  assign rsp_rdata  = (rsp_valid && !we_q && !addr_err) ? mem_rdata : '0;
  assign err_count  = err_count_q;
  assign clear_done = clear_done_q;

endmodule
